ce_rs_tx_sched: RTL
===================

Name: ce_rs_tx_sched

Overview:
Scheduler in front of the CE reference-signal ROM generator. It takes per-symbol RS generation requests from NUM_REQ requesters (UE streams) and arbitrates between them round-robin. For each grant it drives one contiguous valid burst of exactly fftpts cycles, plus a UE select and start/end markers. A guard gap after every burst lets the generator's address counter return to 0. Delayed output flags are aligned to the generator's 1-clk ROM read latency.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
wFftpts, 12, width of the FFT-points field
MAX_FFTPTS, 2048, largest legal burst length (ROM depth, 11-bit address)
GAP_CYC, 1, idle cycles forced after each burst (minimum 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
flush  in  1  synchronous abort of the current burst
req_valid  in  NUM_REQ  request per requester, held until granted
req_fftpts  in  NUM_REQ*wFftpts  burst length per requester; requester i at bits [i*wFftpts +: wFftpts]
req_ready  out  NUM_REQ  one-hot grant pulse, 1 cycle
gen_valid  out  1  drives generator sink_valid
gen_fftpts  out  wFftpts  latched length of the current burst
gen_ue_sel  out  $clog2(NUM_REQ) (min 1)  index of the granted requester
gen_sop / gen_eop  out  1  first / last cycle of the burst (qualified by gen_valid)
out_valid / out_sop / out_eop  out  1  gen_* delayed 1 clk, aligned with ROM data
out_ue_sel  out  $clog2(NUM_REQ)  gen_ue_sel delayed 1 clk
err_fftpts  out  1  1-cycle pulse on an illegal request
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, rr pointer=NUM_REQ-1, and every output is 0.
- FSM states are IDLE, RUN and GAP.
- IDLE, no flush, any req_valid: winner = first set req_valid searching upward from rr+1, with wrap. At that edge:
  - req_ready[winner]=1 for one cycle; rr=winner.
  - Latch fftpts and ue_sel; cnt=0.
- Legal grant (1 ≤ fftpts ≤ MAX_FFTPTS): state becomes RUN. gen_valid=1 and gen_sop=1 in the same cycle as req_ready.
- Illegal grant (fftpts=0 or fftpts>MAX_FFTPTS): err_fftpts pulses, no burst is issued, state stays IDLE, and the rr pointer still advances.
- RUN: gen_valid=1 every cycle; cnt increments each cycle.
  - gen_eop=1 when cnt==fftpts-1. fftpts=1 gives sop and eop in the same cycle.
  - After the eop cycle, state becomes GAP with gap counter=GAP_CYC-1.
- GAP: gen_valid=0 for exactly GAP_CYC cycles, then IDLE. Requests are not granted in GAP.
- Minimum spacing between back-to-back bursts is GAP_CYC+1 cycles from eop to next sop (the extra cycle is the IDLE arbitration cycle).
- Requester protocol:
  - req_valid sampled while req_ready is high counts as consumed; the requester deasserts on the next cycle.
  - req_fftpts must be stable while req_valid is high.
- flush:
  - In RUN: the next cycle has gen_valid=0 with no eop, and state becomes GAP.
  - In IDLE: flush blocks granting.
  - In GAP: no effect.
  - flush and the eop cycle together: eop is still emitted for that cycle, then GAP.
- out_* equal gen_* registered once. They are reset to 0 and carry no combinational path.
- Asynchronous reset mid-burst: all outputs drop immediately; the pending request is re-arbitrated after release.
- gen_fftpts and gen_ue_sel hold their values until the next grant.

Optional Feature:
CE_RS_SCHED_STATS_EN:
- Defined: adds output burst_cnt[15:0], which counts completed (eop) bursts, wraps at 65535→0, and is cleared by reset. Also adds output err_cnt[7:0], which counts illegal requests and saturates at 255.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package ce_pkg holds:
  - the state enum {IDLE, RUN, GAP};
  - the MAX_FFTPTS constant, 2048;
  - the function is_legal_fftpts(wFftpts).
- One sub-module, ce_rr_arb: a parameterised round-robin priority picker. Inputs are req vector and last pointer; outputs are one-hot grant and index; it is purely combinational. The FSM and counters stay in the top module.

Test Plan:
- Single request: req0 with fftpts=4 → req_ready[0] and gen_sop in the same cycle, gen_valid for 4 cycles, eop on the 4th, out_* delayed 1 clk, then 1 gap cycle.
- Contention, GAP_CYC=1: req0 and req1 both held with fftpts=8 and 12 → grants in order 0,1,0,1. Each sop lands 2 cycles after the previous eop, and gen_ue_sel alternates.
- Boundaries: fftpts=1 → sop=eop in one cycle. fftpts=2048 → exactly 2048 valid cycles. fftpts=0 and fftpts=2049 → err_fftpts pulse, req_ready pulse, gen_valid stays 0.
- flush asserted at cnt=5 of a 16-point burst → gen_valid drops on the next cycle, no eop, GAP, then the pending request is granted normally.
- rst_n asserted mid-burst at cnt=100 → all outputs 0 immediately; after release, the held req_valid is re-granted starting at cnt=0.
- With CE_RS_SCHED_STATS_EN: 3 legal bursts and 1 illegal request → burst_cnt=3, err_cnt=1. Without the macro, the design compiles with the ports absent.

Source files
------------

// File: rtl/ce_pkg.sv
// Shared types and helpers for the CE reference-signal TX scheduler.
package ce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // ROM depth of the reference-signal generator (11-bit address).
  localparam int MAX_FFTPTS = 2048;

  function automatic logic is_legal_fftpts(input int unsigned fftpts,
                                           input int unsigned max_fftpts);
    return (fftpts >= 1) && (fftpts <= max_fftpts);
  endfunction

endpackage

// File: rtl/ce_rr_arb.sv
// Combinational round-robin picker: first set request above the last winner, with wrap.
module ce_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin : pick
    int pos;
    // NOTE: every output gets a default before the search so no path leaves a latch.
    pos   = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/ce_rs_tx_sched.sv
// Round-robin burst scheduler feeding the CE RS ROM generator.
// Optional CE_RS_SCHED_STATS_EN adds burst_cnt / err_cnt statistics outputs.
module ce_rs_tx_sched
  import ce_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int wFftpts    = 12,
  parameter int MAX_FFTPTS = ce_pkg::MAX_FFTPTS,
  parameter int GAP_CYC    = 1,
  localparam int UE_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*wFftpts-1:0] req_fftpts,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       gen_valid,
  output logic [wFftpts-1:0]         gen_fftpts,
  output logic [UE_W-1:0]            gen_ue_sel,
  output logic                       gen_sop,
  output logic                       gen_eop,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [UE_W-1:0]            out_ue_sel,
  output logic                       err_fftpts,
  output logic                       busy
`ifdef CE_RS_SCHED_STATS_EN
  ,
  output logic [15:0]                burst_cnt,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e             state;
  logic [wFftpts-1:0] cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [UE_W-1:0]    rr_ptr;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [UE_W-1:0]    arb_idx;
  logic               arb_any;
  logic [wFftpts-1:0] win_fftpts;
  logic               win_legal;

  // A requester still showing req_valid during its grant pulse was already served.
  assign arb_req = req_valid & ~req_ready;

  ce_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (UE_W)
  ) u_arb (
    .req   (arb_req),
    .last  (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    win_fftpts = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_grant[i]) win_fftpts = req_fftpts[i*wFftpts +: wFftpts];
  end

  assign win_legal = is_legal_fftpts(32'(win_fftpts), MAX_FFTPTS);
  assign busy      = (state != IDLE);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gap_cnt    <= '0;
      rr_ptr     <= UE_W'(NUM_REQ - 1);
      req_ready  <= '0;
      gen_valid  <= 1'b0;
      gen_fftpts <= '0;
      gen_ue_sel <= '0;
      gen_sop    <= 1'b0;
      gen_eop    <= 1'b0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_ue_sel <= '0;
      err_fftpts <= 1'b0;
`ifdef CE_RS_SCHED_STATS_EN
      burst_cnt  <= '0;
      err_cnt    <= '0;
`endif
    end else begin
      req_ready  <= '0;
      err_fftpts <= 1'b0;
      out_valid  <= gen_valid;
      out_sop    <= gen_sop;
      out_eop    <= gen_eop;
      out_ue_sel <= gen_ue_sel;
`ifdef CE_RS_SCHED_STATS_EN
      if (gen_valid && gen_eop) burst_cnt <= burst_cnt + 16'd1;
`endif
      unique case (state)
        IDLE: begin
          if (!flush && arb_any) begin
            req_ready  <= arb_grant;
            rr_ptr     <= arb_idx;
            gen_fftpts <= win_fftpts;
            gen_ue_sel <= arb_idx;
            cnt        <= '0;
            if (win_legal) begin
              state     <= RUN;
              gen_valid <= 1'b1;
              gen_sop   <= 1'b1;
              gen_eop   <= (win_fftpts == wFftpts'(1));
            end else begin
              err_fftpts <= 1'b1;
`ifdef CE_RS_SCHED_STATS_EN
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
            end
          end
        end
        RUN: begin
          gen_sop <= 1'b0;
          // An eop already on the outputs completes even if flush arrives with it.
          if (flush || gen_eop) begin
            state     <= GAP;
            gap_cnt   <= GAP_W'(GAP_CYC - 1);
            gen_valid <= 1'b0;
            gen_eop   <= 1'b0;
          end else begin
            cnt     <= cnt + wFftpts'(1);
            gen_eop <= ((cnt + wFftpts'(1)) == (gen_fftpts - wFftpts'(1)));
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
